// File: rtl/w_burst_tracker.sv
// w_burst_tracker: takes one AW entry at a time from the pending-address
// queue and steers the matching W beats toward the slave side. It produces
// the address of every beat, the authoritative slave WLAST, and a one-cycle
// error pulse when the master's WLAST disagrees with the beat count.
//
// Handshake semantics: a W beat transfers on a cycle where the sender holds
// VALID high and the receiver holds READY high. VALID never waits on READY.
// Inside a burst the tracker is transparent: S_WVALID follows WVALID and
// WREADY follows S_WREADY. A beat therefore counts as WVALID & S_WREADY
// while a burst is active. Outside a burst both directions are held off.
module w_burst_tracker #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int SIZE_WIDTH = 3
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    // AW queue front
    input  logic                    fifo_empty,
    output logic                    fifo_pop,
    input  logic [ID_WIDTH-1:0]     front_AWID,
    input  logic [ADDR_WIDTH-1:0]   front_AWADDR,
    input  logic [LEN_WIDTH-1:0]    front_AWLEN,
    input  logic [SIZE_WIDTH-1:0]   front_AWSIZE,
    input  logic [1:0]              front_AWBURST,
    // master W channel
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    // slave W channel
    output logic [DATA_WIDTH-1:0]   S_WDATA,
    output logic [DATA_WIDTH/8-1:0] S_WSTRB,
    output logic                    S_WLAST,
    output logic                    S_WVALID,
    input  logic                    S_WREADY,
    // burst status
    output logic [ID_WIDTH-1:0]     S_WID,
    output logic [ADDR_WIDTH-1:0]   beat_addr,
    output logic                    busy,
    output logic                    wlast_err,
    // FSM state for checkers: 0 = IDLE, 1 = BURST
    output logic                    dbg_state
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [ID_WIDTH-1:0]    id_q, id_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [SIZE_WIDTH-1:0]  size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;

    logic                   in_burst;
    logic                   load;
    logic                   last_beat;
    logic                   hs;

    logic [ADDR_WIDTH-1:0]  inc;
    logic [ADDR_WIDTH-1:0]  len_plus1;
    logic [ADDR_WIDTH-1:0]  wrap_mask;
    logic [ADDR_WIDTH-1:0]  incr_addr;
    logic [ADDR_WIDTH-1:0]  addr_next;

    assign in_burst  = (state_q == ST_BURST);
    assign load      = (state_q == ST_IDLE) && !fifo_empty;
    assign last_beat = (cnt_q == len_q);
    assign hs        = in_burst && WVALID && S_WREADY;

    // Beat address arithmetic. The wrap mask spans (len+1) beats of
    // (1<<size) bytes; non power-of-two lengths use the same formula.
    assign inc       = ADDR_ONE << size_q;
    assign len_plus1 = {{(ADDR_WIDTH-LEN_WIDTH){1'b0}}, len_q} + ADDR_ONE;
    assign wrap_mask = (len_plus1 << size_q) - ADDR_ONE;
    assign incr_addr = addr_q + inc;

    // Address of the following beat for the latched burst type.
    always_comb begin
        addr_next = addr_q;
        case (burst_q)
            2'b01:   addr_next = incr_addr;
            2'b10:   addr_next = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
            default: addr_next = addr_q;  // FIXED and reserved
        endcase
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: load from the queue, leave after the last beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (load) state_d = ST_BURST;
            ST_BURST: if (hs && last_beat) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: control is only asserted while a burst is active.
    always_comb begin
        fifo_pop  = 1'b0;
        WREADY    = 1'b0;
        S_WVALID  = 1'b0;
        S_WLAST   = 1'b0;
        wlast_err = 1'b0;
        case (state_q)
            // Pop is held off while reset is asserted so the queue keeps
            // its entries until the tracker is running again.
            ST_IDLE: fifo_pop = load && ARESETn;
            ST_BURST: begin
                WREADY    = S_WREADY;
                S_WVALID  = WVALID;
                S_WLAST   = last_beat;
                wlast_err = hs && (WLAST != last_beat);
            end
            default: ;
        endcase
    end

    // Burst context next state: capture at load, step on non-final beats.
    always_comb begin
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        if (load) begin
            id_d    = front_AWID;
            addr_d  = front_AWADDR;
            len_d   = front_AWLEN;
            size_d  = front_AWSIZE;
            burst_d = front_AWBURST;
            cnt_d   = '0;
        end else if (hs && !last_beat) begin
            cnt_d  = cnt_q + CNT_ONE;
            addr_d = addr_next;
        end
    end

    // Burst context registers; id and address hold their values in IDLE.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
        end
    end

    // Payload is a zero-latency pass-through; master WLAST is not forwarded.
    assign S_WDATA   = WDATA;
    assign S_WSTRB   = WSTRB;
    assign S_WID     = id_q;
    assign beat_addr = addr_q;
    assign busy      = in_burst;
    assign dbg_state = state_q;

endmodule
